// File: rtl/uart_image_loader_pkg.sv
// Shared constants for the UART image loader and the HDMI read side: frame geometry defaults,
// header bytes and the 2-bit loader state encoding.
package uart_image_loader_pkg;

  localparam int IMG_W_DEFAULT = 160;
  localparam int IMG_H_DEFAULT = 120;
  localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;
  localparam int TIMEOUT_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    HUNT0  = 2'd0,
    HUNT1  = 2'd1,
    PIXELS = 2'd2,
    CHECK  = 2'd3
  } loader_state_t;

  // Address width for a frame of npix pixels; never narrower than one bit.
  function automatic int addr_width(input int npix);
    return (npix > 1) ? $clog2(npix) : 1;
  endfunction

endpackage

// File: rtl/uart_image_loader_if.sv
// Byte-in / pixel-write-out bundle of the image loader. The slave side is the loader itself,
// the master side is whoever supplies received bytes and consumes writes and status.
interface uart_image_loader_if
  import uart_image_loader_pkg::*;
#(
  parameter int ADDR_W = addr_width(IMG_W_DEFAULT * IMG_H_DEFAULT)
);
  logic              rx_valid_in;
  logic [7:0]        rx_data_in;
  logic              wr_en_out;
  logic [ADDR_W-1:0] wr_addr_out;
  logic [7:0]        wr_data_out;
  logic              busy_out;
  logic              frame_done_out;
  logic              frame_err_out;
  logic              frame_ok_out;

  modport master (
    output rx_valid_in, rx_data_in,
    input  wr_en_out, wr_addr_out, wr_data_out, busy_out,
    input  frame_done_out, frame_err_out, frame_ok_out
  );

  modport slave (
    input  rx_valid_in, rx_data_in,
    output wr_en_out, wr_addr_out, wr_data_out, busy_out,
    output frame_done_out, frame_err_out, frame_ok_out
  );
endinterface

// File: rtl/uart_image_loader_byte_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags the cycle in which the
// count reaches LIMIT-1. A clear in that same cycle suppresses the expiry.
module uart_image_loader_byte_timeout #(
  parameter int LIMIT = 1000000
) (
  input  logic clk_in,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  assign expire = enable && !clear && (count == LAST);

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear || !enable || expire) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/uart_image_loader.sv
// Hunts a two-byte header in the received byte stream, then writes one frame of pixels in raster
// order to the frame buffer. Define UART_IMAGE_LOADER_CHECKSUM_EN to require an XOR trailer byte.
module uart_image_loader
  import uart_image_loader_pkg::*;
#(
  parameter int          IMG_W          = IMG_W_DEFAULT,
  parameter int          IMG_H          = IMG_H_DEFAULT,
  parameter logic [7:0]  SYNC0          = SYNC0_DEFAULT,
  parameter logic [7:0]  SYNC1          = SYNC1_DEFAULT,
  parameter int          TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input logic               clk_in,
  input logic               n_rst,
  uart_image_loader_if.slave bus
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int ADDR_W = addr_width(NPIX);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

  loader_state_t     state;
  logic [ADDR_W-1:0] pix_count;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_en;
  logic              frame_done;
  logic              frame_err;
  logic              frame_ok;
  logic              expire;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  uart_image_loader_byte_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_in (clk_in),
    .n_rst  (n_rst),
    .clear  (bus.rx_valid_in),
    .enable (state != HUNT0),
    .expire (expire)
  );

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      state      <= HUNT0;
      pix_count  <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_ok   <= 1'b0;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      // A byte arriving in the expiry cycle takes priority over the timeout.
      if (bus.rx_valid_in) begin
        case (state)
          HUNT0: begin
            if (bus.rx_data_in == SYNC0) state <= HUNT1;
          end
          HUNT1: begin
            if (bus.rx_data_in == SYNC1) begin
              state     <= PIXELS;
              pix_count <= '0;
              frame_ok  <= 1'b0;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
              csum      <= '0;
`endif
            end else if (bus.rx_data_in != SYNC0) begin
              state <= HUNT0;
            end
          end
          PIXELS: begin
            wr_en   <= 1'b1;
            wr_addr <= pix_count;
            wr_data <= bus.rx_data_in;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
            csum    <= csum ^ bus.rx_data_in;
`endif
            if (pix_count == LAST_PIX) begin
              pix_count <= '0;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
              state     <= CHECK;
`else
              state      <= HUNT0;
              frame_done <= 1'b1;
              frame_ok   <= 1'b1;
`endif
            end else begin
              pix_count <= pix_count + ADDR_W'(1);
            end
          end
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
          CHECK: begin
            state <= HUNT0;
            if (bus.rx_data_in == csum) begin
              frame_done <= 1'b1;
              frame_ok   <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
`endif
          default: state <= HUNT0;
        endcase
      end else if (expire) begin
        state     <= HUNT0;
        pix_count <= '0;
        frame_err <= 1'b1;
      end
    end
  end

  assign bus.wr_en_out      = wr_en;
  assign bus.wr_addr_out    = wr_addr;
  assign bus.wr_data_out    = wr_data;
  assign bus.busy_out       = (state != HUNT0);
  assign bus.frame_done_out = frame_done;
  assign bus.frame_err_out  = frame_err;
  assign bus.frame_ok_out   = frame_ok;
endmodule

// File: tb/tb_uart_image_loader.sv
// Self-checking bench for uart_image_loader on a 4x2 frame with a 50-cycle inter-byte timeout;
// a byte-stream protocol model predicts writes, pulses and the frame_ok level.
module tb_uart_image_loader;
  import uart_image_loader_pkg::*;

  localparam int W = 4;
  localparam int H = 2;
  localparam int NPIX = W * H;
  localparam int TMO = 50;
  localparam logic [7:0] S0 = 8'hA5;
  localparam logic [7:0] S1 = 8'h5A;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b1;

  uart_image_loader_if #(.ADDR_W(3)) bus ();

  uart_image_loader #(
    .IMG_W          (W),
    .IMG_H          (H),
    .SYNC0          (S0),
    .SYNC1          (S1),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_in (clk),
    .n_rst  (n_rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int addr; int data;} wr_t;
  wr_t obs_q[$];
  wr_t exp_q[$];
  int obs_done = 0, obs_err = 0, obs_done_wr = 0;

  always @(negedge clk) begin
    if (bus.wr_en_out) obs_q.push_back('{int'(bus.wr_addr_out), int'(bus.wr_data_out)});
    if (bus.frame_done_out) obs_done++;
    if (bus.frame_err_out) obs_err++;
    if (bus.frame_done_out && bus.wr_en_out && bus.wr_addr_out == 3'(NPIX - 1)) obs_done_wr++;
  end

  // Protocol model: 0 hunting header, 1 saw first header byte, 2 receiving pixels, 3 awaiting trailer.
  int m_mode = 0, m_idx = 0, m_last = 0, exp_done = 0, exp_err = 0;
  logic m_ok = 1'b0;
  logic [7:0] m_xor = 8'h00;

  task automatic model_byte(input logic [7:0] b, input int gap);
    if (m_mode != 0 && gap > TMO) begin
      exp_err++;
      m_mode = 0;
    end
    case (m_mode)
      0: if (b == S0) m_mode = 1;
      1: begin
        if (b == S1) begin
          m_mode = 2; m_idx = 0; m_ok = 1'b0; m_xor = 8'h00;
        end else if (b != S0) begin
          m_mode = 0;
        end
      end
      2: begin
        exp_q.push_back('{m_idx, int'(b)});
        m_xor ^= b;
        m_idx++;
        if (m_idx == NPIX) begin
          if (CSUM) m_mode = 3;
          else begin exp_done++; m_ok = 1'b1; m_mode = 0; end
        end
      end
      default: begin
        if (b == m_xor) begin exp_done++; m_ok = 1'b1; end
        else exp_err++;
        m_mode = 0;
      end
    endcase
  endtask

  task automatic send(input logic [7:0] b, input int idle);
    repeat (idle) begin @(posedge clk); #1; end
    bus.rx_data_in = b;
    bus.rx_valid_in = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid_in = 1'b0;
    model_byte(b, cyc - m_last);
    m_last = cyc;
  endtask

  // Long enough silence for any pending write to appear and any open frame to time out.
  task automatic tail();
    repeat (60) begin @(posedge clk); #1; end
    if (m_mode != 0) begin exp_err++; m_mode = 0; end
  endtask

  task automatic clear_sb();
    obs_q.delete(); exp_q.delete();
    obs_done = 0; obs_err = 0; obs_done_wr = 0; exp_done = 0; exp_err = 0;
  endtask

  function automatic int first_diff();
    int n;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (obs_q[i].addr != exp_q[i].addr || obs_q[i].data != exp_q[i].data) return i;
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int rand_idle();
    int r;
    r = $urandom_range(99);
    if (r < 70) return $urandom_range(2);
    if (r < 85) return $urandom_range(TMO + 2, TMO - 3);
    return $urandom_range(10, 3);
  endfunction

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(99);
    if (r < 25) return S0;
    if (r < 40) return S1;
    return 8'($urandom_range(255));
  endfunction

  task automatic send_frame(input logic [7:0] first_pix, input bit random_pix, input int max_idle);
    logic [7:0] x;
    logic [7:0] p;
    x = 8'h00;
    send(S0, $urandom_range(max_idle));
    send(S1, $urandom_range(max_idle));
    for (int i = 0; i < NPIX; i++) begin
      p = random_pix ? 8'($urandom_range(255)) : first_pix + 8'(i);
      x ^= p;
      send(p, $urandom_range(max_idle));
    end
    if (CSUM) send(x, $urandom_range(max_idle));
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    #1;
    checks++;
    if ({bus.wr_en_out, bus.busy_out, bus.frame_done_out, bus.frame_err_out, bus.frame_ok_out} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b required=00000", {bus.wr_en_out, bus.busy_out,
               bus.frame_done_out, bus.frame_err_out, bus.frame_ok_out});
    end
    checks++;
    if ({bus.wr_addr_out, bus.wr_data_out} !== 11'h0) begin
      failures++;
      $display("FAIL reset_bus got addr=%0h data=%0h required 0/0", bus.wr_addr_out, bus.wr_data_out);
    end
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    m_mode = 0; m_ok = 1'b0; m_last = cyc;
    clear_sb();
    $display("test_reset: done");
  endtask

  task automatic test_frame();
    int d;
    clear_sb();
    send_frame(8'h00, 1'b0, 0);
    send_frame(8'h00, 1'b1, 2);
    send_frame(8'h00, 1'b1, 2);
    repeat (4) begin @(posedge clk); #1; end
    checks++; d = first_diff();
    if (d != -1) begin failures++; $display("FAIL frame_writes idx=%0d got_n=%0d required_n=%0d", d, obs_q.size(), exp_q.size()); end
    checks++;
    if (obs_done != exp_done) begin failures++; $display("FAIL frame_done got=%0d required=%0d", obs_done, exp_done); end
    checks++;
    if (obs_done_wr != (CSUM ? 0 : exp_done)) begin failures++; $display("FAIL frame_done_with_last_write got=%0d required=%0d", obs_done_wr, CSUM ? 0 : exp_done); end
    checks++;
    if (obs_err != exp_err) begin failures++; $display("FAIL frame_err got=%0d required=%0d", obs_err, exp_err); end
    checks++;
    if (bus.frame_ok_out !== m_ok) begin failures++; $display("FAIL frame_ok got=%b required=%b", bus.frame_ok_out, m_ok); end
    $display("test_frame: writes=%0d done=%0d", obs_q.size(), obs_done);
  endtask

  task automatic test_resync();
    int d;
    clear_sb();
    send(8'h11, 0); send(S0, 1); send(S0, 0); send(S1, 2);
    send(S0, 0); send(S1, 0); send(S0, 1); send(S0, 0);
    for (int i = 4; i < NPIX; i++) send(8'($urandom_range(255)), $urandom_range(2));
    if (CSUM) send(m_xor, 0);
    checks++;
    if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL resync_busy got=%b required=0", bus.busy_out); end
    repeat (4) begin @(posedge clk); #1; end
    checks++; d = first_diff();
    if (d != -1) begin failures++; $display("FAIL resync_writes idx=%0d got_n=%0d required_n=%0d", d, obs_q.size(), exp_q.size()); end
    checks++;
    if (obs_done != exp_done || obs_err != exp_err) begin failures++; $display("FAIL resync_pulses got done=%0d err=%0d required done=%0d err=%0d", obs_done, obs_err, exp_done, exp_err); end
    $display("test_resync: writes=%0d done=%0d", obs_q.size(), obs_done);
  endtask

  task automatic test_timeout();
    int d;
    clear_sb();
    send(S0, 0); send(S1, 0);
    for (int i = 0; i < 3; i++) send(8'($urandom_range(255)), 0);
    tail();
    checks++;
    if (obs_err != exp_err) begin failures++; $display("FAIL timeout_err got=%0d required=%0d", obs_err, exp_err); end
    checks++;
    if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL timeout_busy got=%b required=0", bus.busy_out); end
    send_frame(8'h00, 1'b1, 1);
    repeat (4) begin @(posedge clk); #1; end
    checks++; d = first_diff();
    if (d != -1) begin failures++; $display("FAIL timeout_writes idx=%0d got_n=%0d required_n=%0d", d, obs_q.size(), exp_q.size()); end
    checks++;
    if (obs_done != exp_done || bus.frame_ok_out !== m_ok) begin failures++; $display("FAIL timeout_recover got done=%0d ok=%b required done=%0d ok=%b", obs_done, bus.frame_ok_out, exp_done, m_ok); end
    $display("test_timeout: err=%0d done=%0d", obs_err, obs_done);
  endtask

  task automatic test_expiry_edge();
    int d;
    clear_sb();
    send(S0, 0); send(S1, TMO - 1);
    for (int i = 0; i < NPIX; i++) send(8'h30 + 8'(i), (i == 3) ? TMO - 1 : 0);
    if (CSUM) send(m_xor, TMO - 1);
    send(S0, 3); send(S1, 0); send(8'h77, 0);
    send(8'h66, TMO);
    tail();
    checks++; d = first_diff();
    if (d != -1) begin failures++; $display("FAIL expiry_writes idx=%0d got_n=%0d required_n=%0d", d, obs_q.size(), exp_q.size()); end
    checks++;
    if (obs_err != exp_err) begin failures++; $display("FAIL expiry_err got=%0d required=%0d", obs_err, exp_err); end
    checks++;
    if (obs_done != exp_done) begin failures++; $display("FAIL expiry_done got=%0d required=%0d", obs_done, exp_done); end
    $display("test_expiry_edge: writes=%0d err=%0d", obs_q.size(), obs_err);
  endtask

  task automatic test_reset_mid();
    int d;
    clear_sb();
    send(S0, 0); send(S1, 0);
    for (int i = 0; i < 3; i++) send(8'($urandom_range(255)), 0);
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (bus.busy_out !== 1'b1) begin failures++; $display("FAIL midreset_busy_before got=%b required=1", bus.busy_out); end
    n_rst = 1'b0;
    #1;
    checks++;
    if ({bus.wr_en_out, bus.busy_out, bus.frame_done_out, bus.frame_err_out, bus.frame_ok_out,
         bus.wr_addr_out, bus.wr_data_out} !== 16'h0) begin
      failures++;
      $display("FAIL midreset_outputs got busy=%b ok=%b addr=%0h data=%0h required all 0", bus.busy_out, bus.frame_ok_out, bus.wr_addr_out, bus.wr_data_out);
    end
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    m_mode = 0; m_ok = 1'b0;
    send_frame(8'h00, 1'b1, 1);
    repeat (4) begin @(posedge clk); #1; end
    checks++; d = first_diff();
    if (d != -1) begin failures++; $display("FAIL midreset_writes idx=%0d got_n=%0d required_n=%0d", d, obs_q.size(), exp_q.size()); end
    checks++;
    if (obs_done != exp_done || obs_err != exp_err) begin failures++; $display("FAIL midreset_pulses got done=%0d err=%0d required done=%0d err=%0d", obs_done, obs_err, exp_done, exp_err); end
    $display("test_reset_mid: writes=%0d done=%0d", obs_q.size(), obs_done);
  endtask

  task automatic test_random();
    int d;
    int nb;
    clear_sb();
    for (int r = 0; r < 40; r++) begin
      nb = $urandom_range(14, 1);
      if ($urandom_range(1) == 1) begin send(S0, rand_idle()); send(S1, rand_idle()); end
      for (int k = 0; k < nb; k++) send(rand_byte(), rand_idle());
    end
    tail();
    checks++; d = first_diff();
    if (d != -1) begin failures++; $display("FAIL random_writes idx=%0d got_n=%0d required_n=%0d", d, obs_q.size(), exp_q.size()); end
    checks++;
    if (obs_done != exp_done) begin failures++; $display("FAIL random_done got=%0d required=%0d", obs_done, exp_done); end
    checks++;
    if (obs_err != exp_err) begin failures++; $display("FAIL random_err got=%0d required=%0d", obs_err, exp_err); end
    checks++;
    if (bus.frame_ok_out !== m_ok || bus.busy_out !== 1'b0) begin failures++; $display("FAIL random_levels got ok=%b busy=%b required ok=%b busy=0", bus.frame_ok_out, bus.busy_out, m_ok); end
    $display("test_random: writes=%0d done=%0d err=%0d", obs_q.size(), obs_done, obs_err);
  endtask

`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] pat [4];
    logic [7:0] trailer [2];
    pat = '{8'h01, 8'h02, 8'h04, 8'h08};
    trailer = '{8'h00, 8'hFF};
    for (int t = 0; t < 2; t++) begin
      clear_sb();
      send(S0, 0); send(S1, 0);
      for (int i = 0; i < NPIX; i++) send(pat[i % 4], 0);
      send(trailer[t], 0);
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if (obs_done != ((t == 0) ? 1 : 0) || obs_err != ((t == 0) ? 0 : 1)) begin
        failures++;
        $display("FAIL checksum_pulses trailer=%0h got done=%0d err=%0d", trailer[t], obs_done, obs_err);
      end
      checks++;
      if (bus.frame_ok_out !== ((t == 0) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL checksum_ok trailer=%0h got=%b required=%b", trailer[t], bus.frame_ok_out, (t == 0) ? 1'b1 : 1'b0);
      end
      $display("test_checksum: trailer=%0h done=%0d err=%0d", trailer[t], obs_done, obs_err);
    end
  endtask
`endif

  initial begin
    bus.rx_valid_in = 1'b0;
    bus.rx_data_in = 8'h00;
    test_reset();
    test_frame();
    test_resync();
    test_timeout();
    test_expiry_edge();
    test_reset_mid();
    test_random();
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
